// File: rtl/limb_mul_iter.sv
// rtl/limb_mul_iter.sv - iterative WIDTH x WIDTH unsigned multiplier built on one LIMB x LIMB multiplier
// Full-product or low-half-only mode; valid/ready handshakes on input and output.
module limb_mul_iter #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     Xin,
  input  logic [WIDTH-1:0]     Yin,
  output logic [2*WIDTH-1:0]   P,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int N  = WIDTH / LIMB;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int LW = 2 * LIMB;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic            mode_q, mode_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic [PW-1:0]   p_q, p_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;

  logic [LIMB-1:0] x_limb, y_limb;
  logic [LW-1:0]   pp;
  logic [PW-1:0]   pp_shifted, acc_sum;
  int              shamt;
  logic            row_last, pair_last;

  always_comb begin
    x_limb     = x_q[int'(i_q)*LIMB +: LIMB];
    y_limb     = y_q[int'(j_q)*LIMB +: LIMB];
    pp         = LW'(x_limb) * LW'(y_limb);
    shamt      = LIMB * (int'(i_q) + int'(j_q));
    pp_shifted = PW'(pp) << shamt;
    acc_sum    = acc_q + pp_shifted;
    // In low-half mode each row stops at the anti-diagonal i+j = N-1.
    row_last   = mode_q ? ((int'(i_q) + int'(j_q)) == N - 1) : (int'(j_q) == N - 1);
    pair_last  = (int'(i_q) == N - 1) && row_last;

    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = Xin;
          y_d        = Yin;
          mode_d     = mode;
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
          state_d    = MUL;
        end
      end
      MUL: begin
        acc_d = acc_sum;
        if (pair_last) begin
          p_d         = mode_q ? {{WIDTH{1'b0}}, acc_sum[WIDTH-1:0]} : acc_sum;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end else if (row_last) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign P         = p_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_limb_mul_iter.sv
// tb/tb_limb_mul_iter.sv - self-checking bench for limb_mul_iter (N=4 and N=1 instances)
module tb_limb_mul_iter;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [255:0] Xin, Yin;
  logic [511:0] P;

  logic         iv1, ir1, m1, ov1, or1, b1;
  logic [63:0]  x1, y1;
  logic [127:0] p1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  limb_mul_iter #(.WIDTH(256), .LIMB(64)) u_dut (
    .clock(clock), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .Xin(Xin), .Yin(Yin), .P(P), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  limb_mul_iter #(.WIDTH(64), .LIMB(64)) u_dut1 (
    .clock(clock), .reset(rst_n), .in_valid(iv1), .in_ready(ir1),
    .mode(m1), .Xin(x1), .Yin(y1), .P(p1), .out_valid(ov1),
    .out_ready(or1), .busy(b1)
  );

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] ref_p(logic [255:0] x, logic [255:0] y, bit m);
    logic [511:0] full;
    full = {256'b0, x} * {256'b0, y};
    return m ? {256'b0, full[255:0]} : full;
  endfunction

  function automatic int k_of(bit m);
    return m ? N * (N + 1) / 2 : N * N;
  endfunction

  function automatic logic [255:0] rand_w();
    logic [255:0] v;
    case ($urandom % 8)
      0: v = '0;
      1: v = '1;
      2: v = 256'(1) << $urandom_range(0, 255);
      default: for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    endcase
    return v;
  endfunction

  task automatic start_op(logic [255:0] x, logic [255:0] y, bit m);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 100) check("in_ready_timeout", 1, 0);
    Xin = x; Yin = y; mode = m; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, input bit rnd_ready);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (rnd_ready) out_ready = $urandom % 2;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic op1(logic [63:0] x, logic [63:0] y, bit m, logic [127:0] exp, string tag);
    int lat = 0;
    x1 = x; y1 = y; m1 = m; iv1 = 1'b1;
    @(posedge clock); #1;
    iv1 = 1'b0;
    while (!ov1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 1);
    check(tag, p1, exp);
    or1 = 1'b1;
    @(posedge clock); #1;
    or1 = 1'b0;
    check({tag, "_rdy"}, ir1, 1);
  endtask

  initial begin
    logic [255:0] ones, a, b, c, d, x, y;
    logic [511:0] e;
    int lat;
    bit m, r;

    rst_n = 1'b0; in_valid = 0; out_ready = 0; mode = 0; Xin = '0; Yin = '0;
    iv1 = 0; or1 = 0; m1 = 0; x1 = '0; y1 = '0;
    ones = '1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_P", P, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // small product, full mode
    start_op(256'd3, 256'd5, 1'b0);
    check("busy_mul", busy, 1);
    check("in_ready_mul", in_ready, 0);
    wait_done(lat, 1'b0);
    check("lat_3x5", lat, 16);
    check("P_3x5", P, 512'd15);
    finish_op();
    check("in_ready_after_hs", in_ready, 1);
    check("ov_after_hs", out_valid, 0);
    check("P_retained", P, 512'd15);

    // all-ones operands, both modes
    e = 512'd0 - (512'd1 << 257) + 512'd1;
    start_op(ones, ones, 1'b0);
    wait_done(lat, 1'b0);
    check("lat_ones_m0", lat, 16);
    check("P_ones_m0", P, e);
    finish_op();
    start_op(ones, ones, 1'b1);
    wait_done(lat, 1'b0);
    check("lat_ones_m1", lat, 10);
    check("P_ones_m1", P, 512'd1);
    finish_op();

    // backpressure with a pending new request
    a = rand_w(); b = rand_w(); c = rand_w(); d = rand_w();
    start_op(a, b, 1'b0);
    wait_done(lat, 1'b0);
    check("lat_bp", lat, 16);
    in_valid = 1'b1; Xin = c; Yin = d; mode = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      check("bp_P", P, ref_p(a, b, 1'b0));
      check("bp_ov", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("bp_hs_ov", out_valid, 0);
    check("bp_hs_in_ready", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("bp_accept_in_ready", in_ready, 0);
    check("bp_accept_busy", busy, 1);
    wait_done(lat, 1'b0);
    check("lat_bp2", lat, 16);
    check("P_bp2", P, ref_p(c, d, 1'b0));
    finish_op();

    // reset in the middle of a computation
    start_op(rand_w(), rand_w(), 1'b0);
    repeat (5) @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ov", out_valid, 0);
    check("midrst_P", P, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    start_op(256'd1 << 64, 256'd1 << 64, 1'b0);
    wait_done(lat, 1'b0);
    check("lat_after_rst", lat, 16);
    check("P_after_rst", P, 512'd1 << 128);
    finish_op();

    // single-limb instance
    op1(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 128'h1_FFFF_FFFF_FFFF_FFFE, "n1_m0");
    op1(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 128'hFFFF_FFFF_FFFF_FFFE, "n1_m1");
    for (int k = 0; k < 30; k++) begin
      logic [63:0]  rx, ry;
      logic [127:0] full;
      rx = {$urandom, $urandom}; ry = {$urandom, $urandom}; m = $urandom % 2;
      full = {64'b0, rx} * {64'b0, ry};
      op1(rx, ry, m, m ? {64'b0, full[63:0]} : full, "n1_rand");
    end

    // randomized back-to-back stream
    for (int k = 0; k < 1000; k++) begin
      int w = 0;
      x = rand_w(); y = rand_w(); m = $urandom % 2;
      start_op(x, y, m);
      Xin = rand_w(); Yin = rand_w(); mode = ~m;
      wait_done(lat, 1'b1);
      check("stream_lat", lat, k_of(m));
      check("stream_P", P, ref_p(x, y, m));
      do begin
        r = (w >= 8) ? 1'b1 : 1'($urandom % 2);
        out_ready = r;
        @(posedge clock); #1;
        w++;
      end while (!r);
      out_ready = 1'b0;
      check("stream_hs_ov", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/limb_mul_iter.md
Name: limb_mul_iter

Overview:
- Parametrised iterative multiplier for WIDTH-bit unsigned operands. A single LIMB x LIMB multiplier is reused over successive cycles.
- Successor to the fixed-width 256-bit pipelined multiplier. Trades throughput for area, adds valid/ready handshakes on both sides, and adds a low-half-only mode used by modular-reduction stages.
- Sits between the operand registers and the reduction unit of the modular multiplier datapath.

Parameters:
- WIDTH, 256, operand width in bits; must be a multiple of LIMB.
- LIMB, 64, limb width in bits; width of the single hardware multiplier.
- N, WIDTH/LIMB (derived localparam), number of limbs; N >= 1.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  block can accept operands
- mode  input  1  0 = full product; 1 = low half only (P[2*WIDTH-1:WIDTH] forced 0)
- Xin  input  WIDTH  multiplicand, unsigned
- Yin  input  WIDTH  multiplier, unsigned
- P  output  2*WIDTH  product, registered
- out_valid  output  1  P holds a completed product
- out_ready  input  1  downstream accepts P
- busy  output  1  high while in state MUL

Behaviour:
- Reset, asynchronous while reset==0:
  - state=IDLE; P=0, out_valid=0, busy=0, in_ready=1.
  - Internal accumulator, limb indices i and j, and the operand and mode registers are all 0.
- Reset asserted mid-operation aborts the computation. No out_valid is produced for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch Xin, Yin and mode; clear accumulator; set i=0, j=0; go to MUL.
  - MUL: in_ready=0, busy=1. Each cycle, acc <= acc + (X[i] * Y[j] << (LIMB*(i+j))), where X[k] = X[LIMB*k +: LIMB].
    - Index advance:
      - mode 0: j increments up to N-1, then j=0 and i increments.
      - mode 1: j increments up to N-1-i, then j=0 and i increments. Pairs with i+j >= N are skipped.
    - On the final pair (mode 0: i=j=N-1; mode 1: i=N-1, j=0):
      - P <= the final accumulated value. In mode 1, bits [2*WIDTH-1:WIDTH] are cleared.
      - out_valid <= 1; go to DONE.
  - DONE: in_ready=0; P and out_valid held stable. On out_ready: out_valid <= 0; go to IDLE.
- No input is accepted in the same cycle as the output handshake. The earliest next accept is the cycle after returning to IDLE.
- Cycle count K:
  - mode 0: K = N*N.
  - mode 1: K = N*(N+1)/2.
  - Defaults (N=4): K=16 in mode 0, K=10 in mode 1. For N=1, K=1 in both modes.
- Latency: if the accept edge is t0, out_valid is high after edge t0+K.
- Throughput: one product per K+2 cycles at best (accept, K MUL cycles, output handshake).
- Accumulator width is 2*WIDTH; it never overflows. Partial products are 2*LIMB bits, zero-extended before the shift.
- Mode 1 result equals (X*Y) mod 2^WIDTH.
- P retains the last product after the handshake until the next result overwrites it.
- Changes on Xin, Yin or mode while in MUL or DONE have no effect.
- in_valid while not in IDLE is ignored. The upstream source must hold its data until in_ready is high.

Test Plan:
- Reset, then X=3, Y=5, mode 0, out_ready=1:
  - in_ready=1 and P=0 after reset.
  - out_valid rises 16 cycles after accept with P=15.
  - in_ready returns high the cycle after the handshake.
- X=Y=2^256-1, mode 0 -> P = 2^512 - 2^257 + 1. Same operands in mode 1 -> P=1 after 10 cycles; upper 256 bits are 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Meanwhile drive in_valid=1 with new operands.
  - P, out_valid=1 and in_ready=0 remain stable; the new operands are not captured.
  - Release out_ready: handshake completes, and the new operands are accepted the next cycle.
- Reset mid-MUL: pull reset low at cycle 6 of a mode-0 operation.
  - out_valid=0, P=0 and in_ready=1 immediately (asynchronously).
  - After release, a fresh operation X=2^64, Y=2^64 gives P=2^128.
- WIDTH=64, LIMB=64 (N=1): X=0xFFFFFFFFFFFFFFFF, Y=2.
  - mode 0 -> out_valid 1 cycle after accept with P=0x1FFFFFFFFFFFFFFFE.
  - mode 1 -> P=0xFFFFFFFFFFFFFFFE.
- Randomised back-to-back stream of 1000 operand pairs with mixed modes and random out_ready.
  - Every P matches the reference model X*Y or (X*Y) mod 2^WIDTH.
  - The cycle from accept to out_valid is exactly K every time.
